// File: rtl/command_receiver_pkg.sv
// Shared command constants for the command receiver and host-side test code.
// Contents:
//   SYNC_BYTE / OP_*   - frame sync byte and opcode values
//   ST_*               - parser state encodings
//   frame_t            - payload bytes captured between sync and checksum
//   helper functions   - checksum and opcode decoding
package command_receiver_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam logic [7:0] OP_SET_FLAGS     = 8'h01;
    localparam logic [7:0] OP_RUN           = 8'h02;
    localparam logic [7:0] OP_SET_FLAGS_RUN = 8'h03;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_OPCODE   = 3'd1;
    localparam logic [2:0] ST_FLAGS_HI = 3'd2;
    localparam logic [2:0] ST_FLAGS_LO = 3'd3;
    localparam logic [2:0] ST_CHECKSUM = 3'd4;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] flags_hi;
        logic [7:0] flags_lo;
    } frame_t;

    function automatic logic [7:0] frame_checksum(input frame_t f);
        return f.opcode ^ f.flags_hi ^ f.flags_lo;
    endfunction

    function automatic logic opcode_sets_flags(input logic [7:0] op);
        return (op == OP_SET_FLAGS) || (op == OP_SET_FLAGS_RUN);
    endfunction

    function automatic logic opcode_runs(input logic [7:0] op);
        return (op == OP_RUN) || (op == OP_SET_FLAGS_RUN);
    endfunction

endpackage

// File: rtl/uart_receiver.sv
// 8N1 UART byte receiver, LSB first.
// Ports:
//   clock        - system clock (rising edge)
//   reset_n      - asynchronous active-low reset
//   rx_i         - raw asynchronous serial line, idles high
//   byte_o       - last received byte (valid while byte_valid_o is high)
//   byte_valid_o - one-cycle pulse, cycle after a good stop-bit sample
//   frame_err_o  - one-cycle pulse, cycle after a low stop-bit sample
module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int              CNT_W     = $clog2(CLOCKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]       sync_q;
    logic             prev_q,  prev_d;
    logic [1:0]       fill_q,  fill_d;
    logic             armed_q, armed_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        prev_d  = rx_s;
        // After two edges both sync flops hold real line samples, so only then
        // may a high level arm start detection (line low at release is ignored).
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d = armed_q | ((fill_q == 2'd2) & rx_s);

        case (state_q)
            RX_IDLE: begin
                if (armed_q && prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // High at the midpoint means a glitch: drop silently.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            fill_q  <= '0;
            armed_q <= 1'b0;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/command_receiver.sv
// Host command receiver: UART bytes -> framed commands (sync, opcode,
// flags_hi, flags_lo, checksum) -> flags register and run pulse.
// Ports:
//   clock     - system clock (rising edge)
//   reset_n   - asynchronous active-low reset
//   serial_rx - asynchronous UART line from the host, idles high
//   run       - one-cycle pulse commanding a capture/transmit run
//   flags     - registered capture flags, last accepted value
//   error     - one-cycle pulse on any rejected frame or byte
//   busy      - high while a frame is partially received
module command_receiver
    import command_receiver_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 10,
    parameter int TIMEOUT_CLOCKS = 2000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        serial_rx,
    output logic        run,
    output logic [15:0] flags,
    output logic        error,
    output logic        busy
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CLOCKS + 1);
    // Expiry is decided one cycle early so the registered error pulse lands
    // exactly TIMEOUT_CLOCKS cycles after the last byte_valid.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLOCKS - 2);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_receiver #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_uart (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_i        (serial_rx),
        .byte_o      (rx_byte),
        .byte_valid_o(byte_valid),
        .frame_err_o (frame_err)
    );

    logic [2:0]       state_q, state_d;
    frame_t           frame_q, frame_d;
    logic [15:0]      flags_q, flags_d;
    logic             run_q,   run_d;
    logic             error_q, error_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    logic             frame_ok;

    // Unknown opcode and bad checksum both collapse into a single rejection.
    assign frame_ok = (opcode_sets_flags(frame_q.opcode) || opcode_runs(frame_q.opcode))
                      && (rx_byte == frame_checksum(frame_q));

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        flags_d = flags_q;
        run_d   = 1'b0;
        error_d = 1'b0;
        tmo_d   = tmo_q;

        if (frame_err) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            tmo_d   = '0;
        end else if (byte_valid) begin
            // A byte arriving on the expiry cycle takes priority over timeout.
            tmo_d = '0;
            case (state_q)
                ST_IDLE:     if (rx_byte == SYNC_BYTE) state_d = ST_OPCODE;
                ST_OPCODE: begin
                    frame_d.opcode = rx_byte;
                    state_d        = ST_FLAGS_HI;
                end
                ST_FLAGS_HI: begin
                    frame_d.flags_hi = rx_byte;
                    state_d          = ST_FLAGS_LO;
                end
                ST_FLAGS_LO: begin
                    frame_d.flags_lo = rx_byte;
                    state_d          = ST_CHECKSUM;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (frame_ok) begin
                        if (opcode_sets_flags(frame_q.opcode))
                            flags_d = {frame_q.flags_hi, frame_q.flags_lo};
                        run_d = opcode_runs(frame_q.opcode);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                error_d = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            flags_q <= '0;
            run_q   <= 1'b0;
            error_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            flags_q <= flags_d;
            run_q   <= run_d;
            error_q <= error_d;
            tmo_q   <= tmo_d;
        end
    end

    assign run   = run_q;
    assign error = error_q;
    assign flags = flags_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_command_receiver.sv
// Self-checking bench for command_receiver: directed frames plus randomized
// frames, checked by a scoreboard of expected observable output events.
module tb_command_receiver;

    localparam int CPB = 10;
    localparam int TMO = 2000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        serial_rx;
    logic        run;
    logic [15:0] flags;
    logic        error;
    logic        busy;

    always #5 clock = ~clock;

    command_receiver #(
        .CLOCKS_PER_BIT(CPB),
        .TIMEOUT_CLOCKS(TMO)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .serial_rx(serial_rx),
        .run      (run),
        .flags    (flags),
        .error    (error),
        .busy     (busy)
    );

    // One expected observable event: a run pulse, an error pulse or a flags
    // change; lat is the required distance from the last byte_valid (0 = any).
    typedef struct {
        logic        run;
        logic        err;
        logic [15:0] flags;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_flags;
    int          n_vec = 0;
    int          n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc     = 0;
    int          last_bv = -1;
    logic [15:0] prev_flags = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                prev_flags = flags;
                last_bv    = -1;
            end else begin
                if (run && error) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL run_error_overlap: run=%b error=%b at cycle %0d", run, error, cyc);
                end
                if (run || error || flags != prev_flags) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_mis++;
                        $display("FAIL unexpected_event: run=%b error=%b flags=%h, expected nothing", run, error, flags);
                    end else begin
                        e = exp_q.pop_front();
                        check("run", {31'd0, run}, {31'd0, e.run});
                        check("error", {31'd0, error}, {31'd0, e.err});
                        check("flags", {16'd0, flags}, {16'd0, e.flags});
                        if (e.lat > 0) check("latency", cyc - last_bv, e.lat);
                    end
                    prev_flags = flags;
                end
                if (dut.u_uart.byte_valid_o) last_bv = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        logic [7:0] v;
        v = b;
        serial_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            serial_rx = v[i];
            repeat (CPB) @(negedge clock);
        end
        serial_rx = stop_ok;
        repeat (CPB) @(negedge clock);
        serial_rx = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic r, input logic e, input logic [15:0] f, input int lat);
        exp_t x;
        x.run = r; x.err = e; x.flags = f; x.lat = lat;
        exp_q.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        check(name, exp_q.size(), 0);
    endtask

    // Expected behaviour from the frame rules: known opcode and matching
    // XOR checksum -> apply; otherwise one error, nothing applied.
    task automatic send_frame(input logic [7:0] op, input logic [7:0] hi,
                              input logic [7:0] lo, input logic [7:0] chk, input int gmax);
        logic        known, good, rn;
        logic [15:0] nf;
        known = (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
        good  = known && (chk == (op ^ hi ^ lo));
        send_byte(8'hA5, 1'b1); gap($urandom_range(0, gmax));
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        send_byte(op, 1'b1); gap($urandom_range(0, gmax));
        send_byte(hi, 1'b1); gap($urandom_range(0, gmax));
        send_byte(lo, 1'b1); gap($urandom_range(0, gmax));
        if (!good) begin
            push(1'b0, 1'b1, model_flags, 1);
        end else begin
            nf = (op == 8'h02) ? model_flags : {hi, lo};
            rn = (op != 8'h01);
            if (rn || nf != model_flags) push(rn, 1'b0, nf, 1);
            model_flags = nf;
        end
        send_byte(chk, 1'b1);
        wait_drain("frame_drain", 30);
        check("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] op, hi, lo, chk, jb;
        int         kind;
        serial_rx   = 1'b1;
        reset_n     = 1'b0;
        model_flags = '0;
        repeat (3) @(negedge clock);
        check("reset_run", {31'd0, run}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_flags", {16'd0, flags}, 32'd0);
        @(posedge clock); #2 reset_n = 1'b1;
        gap(10);

        // Directed frames.
        send_frame(8'h03, 8'h12, 8'h34, 8'h25, 3);
        check("flags_1234", {16'd0, flags}, 32'h1234);
        send_frame(8'h01, 8'h00, 8'hFF, 8'hFE, 3);
        check("flags_00ff", {16'd0, flags}, 32'h00FF);
        send_frame(8'h02, 8'h00, 8'h00, 8'h02, 3);
        check("flags_keep", {16'd0, flags}, 32'h00FF);
        send_frame(8'h03, 8'h12, 8'h34, 8'h00, 3);
        send_byte(8'h00, 1'b1); gap(5);
        send_byte(8'h7E, 1'b1); gap(5);
        wait_drain("junk_quiet", 5);

        // Framing error mid-frame, then a 3-cycle glitch on the idle line.
        send_byte(8'hA5, 1'b1); gap(3);
        push(1'b0, 1'b1, model_flags, 0);
        send_byte(8'h3C, 1'b0); gap(20);
        wait_drain("stop_err", 30);
        check("busy_after_stop_err", {31'd0, busy}, 32'd0);
        serial_rx = 1'b0; gap(3); serial_rx = 1'b1; gap(40);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        wait_drain("glitch_quiet", 5);

        // Timeout after the opcode byte.
        send_byte(8'hA5, 1'b1); gap(2);
        send_byte(8'h03, 1'b1);
        push(1'b0, 1'b1, model_flags, TMO);
        wait_drain("timeout", TMO + 100);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 5);
            hi   = 8'($urandom_range(0, 255));
            lo   = 8'($urandom_range(0, 255));
            if (kind == 5) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, 1'b1); gap(5);
                wait_drain("rand_junk", 5);
            end else begin
                if (kind <= 2) op = 8'(kind + 1);
                else begin
                    op = 8'($urandom_range(3, 255));
                    if (op == 8'h03) op = 8'h00;
                end
                chk = op ^ hi ^ lo;
                if (kind == 4 || (kind == 3 && $urandom_range(0, 1) == 1))
                    chk = chk ^ 8'($urandom_range(1, 255));
                send_frame(op, hi, lo, chk, 20);
            end
            gap($urandom_range(0, 20));
        end

        // Reset in the middle of the FLAGS_LO byte.
        send_frame(8'h03, 8'h12, 8'h34, 8'h25, 3);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h56, 1'b1);
        serial_rx = 1'b0;
        gap(25);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        @(posedge clock); #2 reset_n = 1'b0;
        #1;
        check("midreset_run", {31'd0, run}, 32'd0);
        check("midreset_error", {31'd0, error}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_flags", {16'd0, flags}, 32'd0);
        model_flags = '0;
        serial_rx   = 1'b1;
        gap(5);
        @(posedge clock); #2 reset_n = 1'b1;
        @(negedge clock);
        gap(10);
        send_frame(8'h01, 8'hAB, 8'hCD, 8'h01 ^ 8'hAB ^ 8'hCD, 3);
        check("flags_after_reset", {16'd0, flags}, 32'hABCD);
        wait_drain("final_drain", 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/command_receiver.md
COMMAND_RECEIVER -- requirements
Module: command_receiver

Interface
REQ-001 The module SHALL have parameter CLOCKS_PER_BIT, default 10, giving clock cycles per UART bit.
REQ-002 The module SHALL have parameter TIMEOUT_CLOCKS, default 2000, giving the maximum idle cycles between bytes inside one frame.
REQ-003 Port clock  input  1  system clock; all logic is on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port serial_rx  input  1  asynchronous UART line from the host; idles high.
REQ-006 Port run  output  1  one-cycle pulse commanding a capture/transmit run.
REQ-007 Port flags  output  16  registered capture flags, last value accepted.
REQ-008 Port error  output  1  one-cycle pulse on any rejected frame or byte.
REQ-009 Port busy  output  1  high while a frame is partially received.

Function
REQ-010 UART format SHALL be 8N1, LSB first, matching the codebase UART transmitter.
REQ-011 serial_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Start detection: synchronized falling edge while the receiver is idle; the line is resampled at CLOCKS_PER_BIT/2; if high, the event is a glitch, discarded, and no error is raised.
REQ-013 Data bits SHALL be sampled every CLOCKS_PER_BIT cycles after the start-bit midpoint.
REQ-014 Stop bit sampled low SHALL discard the byte, pulse error, and return the parser to IDLE.
REQ-015 On a good stop bit, an internal byte_valid SHALL pulse for one cycle, in the cycle after the stop-bit sample.
REQ-016 Frame: 0xA5 sync, opcode, flags_hi, flags_lo, checksum; checksum = opcode XOR flags_hi XOR flags_lo.
REQ-017 Parser states SHALL be IDLE -> OPCODE -> FLAGS_HI -> FLAGS_LO -> CHECKSUM -> IDLE, advancing one state per byte_valid.
REQ-018 In IDLE, bytes other than 0xA5 SHALL be ignored silently.
REQ-019 Opcode 0x01 SET_FLAGS: update flags only; 0x02 RUN: pulse run only, flags unchanged; 0x03: update flags and pulse run in the same cycle.
REQ-020 Any other opcode SHALL be detected in the CHECKSUM state: whole frame consumed, then error pulses and nothing is applied.
REQ-021 A checksum mismatch SHALL pulse error and apply nothing.
REQ-022 A valid frame SHALL update flags and/or pulse run exactly 1 cycle after the checksum byte_valid.
REQ-023 Outside IDLE, TIMEOUT_CLOCKS cycles with no byte_valid SHALL return the parser to IDLE with an error pulse; the counter restarts on every byte_valid.
REQ-024 If timeout expiry and byte_valid coincide, the byte SHALL win and no timeout occurs.
REQ-025 busy SHALL be high in every parser state except IDLE.
REQ-026 run and error SHALL never be high in the same cycle.

Reset
REQ-027 reset_n low SHALL force immediately: run=0, flags=0, error=0, busy=0, parser IDLE, UART receiver idle, synchronizer flops=1.
REQ-028 A frame in progress at reset SHALL be abandoned with no run or error pulse.
REQ-029 After reset release, the first start bit is accepted only after serial_rx is seen high at least once.

Structure
REQ-030 Sync byte, opcode values and parser state encodings SHALL reside in a shared package/include of command constants, reused by host-side test code.
REQ-031 The UART byte receiver (synchronizer, bit timing, shift register, byte_valid, framing error) SHALL be a sub-module named uart_receiver, parameterized by CLOCKS_PER_BIT.

Verification (CLOCKS_PER_BIT=10)
REQ-032 A5 03 12 34 25 -> flags=0x1234, single run pulse 1 cycle after the last byte_valid, error never high.
REQ-033 A5 01 00 FF FE, then A5 02 00 00 02 -> flags=0x00FF after frame 1, no run; frame 2 pulses run, flags stay 0x00FF.
REQ-034 A5 03 12 34 00 (bad checksum) -> one error pulse, flags unchanged, no run; then 00 7E (junk) -> no error.
REQ-035 Byte with stop bit driven low -> one error pulse, parser IDLE; a 3-cycle low glitch on idle line -> nothing.
REQ-036 A5 03 then silence -> error pulse exactly TIMEOUT_CLOCKS cycles after the opcode byte_valid, busy falls.
REQ-037 reset_n low during the FLAGS_LO byte -> outputs zero at once; after release, a full valid frame works normally.
